// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin share of the single-port register bank.
// Define REG_BANK_ARB_ADDR_CHK_EN to reject addresses >= NUM_REGS with err.
module reg_bank_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 256,
    parameter int BANK_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              bank_en,
    output logic              bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

`ifdef REG_BANK_ARB_ADDR_CHK_EN
    localparam bit ADDR_CHK = 1'b1;
`else
    localparam bit ADDR_CHK = 1'b0;
`endif

    localparam int CNT_W =
        (BANK_RD_LAT > 1) ? $clog2(BANK_RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(BANK_RD_LAT - 1);
    localparam logic [ADDR_W:0] ADDR_LIM =
        (ADDR_W + 1)'(NUM_REGS);

    state_t            state;
    state_t            state_d;
    logic              prio;
    logic              win;
    logic [CNT_W-1:0]  cnt;

    logic              sel;
    logic              sel_we;
    logic              sel_bad;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              grant;
    logic              grant_err;
    logic              capture;
    logic              done_ok;

    // Pick the candidate winner and mux its request fields.
    always_comb begin
        sel       = (req0 & req1) ? prio : req1;
        sel_we    = sel ? we1 : we0;
        sel_addr  = sel ? addr1 : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
        sel_bad   = ADDR_CHK &&
                    ({1'b0, sel_addr} >= ADDR_LIM);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic and per-state strobes/outputs.
    always_comb begin
        state_d   = state;
        grant     = 1'b0;
        grant_err = 1'b0;
        capture   = 1'b0;
        done_ok   = 1'b0;
        bank_en   = 1'b0;
        busy      = 1'b1;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req0 | req1) begin
                    grant = 1'b1;
                    if (sel_bad) begin
                        grant_err = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                bank_en = 1'b1;
                if (bank_we) begin
                    done_ok = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    capture = 1'b1;
                    done_ok = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ack0    = ~win;
                ack1    = win;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch winner and bank command; flip priority on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win        <= 1'b0;
            prio       <= 1'b0;
            bank_we    <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
        end else begin
            if (grant) begin
                win <= sel;
                if (!grant_err) begin
                    bank_we    <= sel_we;
                    bank_addr  <= sel_addr;
                    bank_wdata <= sel_wdata;
                end
            end
            if (state == DONE) begin
                prio <= ~win;
            end
        end
    end

    // Count read latency cycles spent in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == ACCESS) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Per-port result registers; only the winner's are touched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
            err0   <= 1'b0;
            err1   <= 1'b0;
        end else begin
            if (grant_err) begin
                if (sel) begin
                    rdata1 <= '0;
                    err1   <= 1'b1;
                end else begin
                    rdata0 <= '0;
                    err0   <= 1'b1;
                end
            end
            if (capture) begin
                if (win) begin
                    rdata1 <= bank_rdata;
                end else begin
                    rdata0 <= bank_rdata;
                end
            end
            if (done_ok) begin
                if (win) begin
                    err1 <= 1'b0;
                end else begin
                    err0 <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed and random traffic vs transaction model.
// Honours REG_BANK_ARB_ADDR_CHK_EN the same way as the design.
module tb_reg_bank_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int NR  = 16;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic          we0 = 1'b0;
    logic          we1 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] wdata0 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          bank_en, bank_we, busy;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_wdata, bank_rdata;

    always #5 clk = ~clk;

    reg_bank_arbiter #(
        .ADDR_W(AW), .DATA_W(DW),
        .NUM_REGS(NR), .BANK_RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .bank_en(bank_en), .bank_we(bank_we),
        .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .busy(busy)
    );

    // Bank model: junk on rdata except exactly LAT cycles after a read.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i * 37 + 5);
        end else if (bank_en && bank_we) begin
            mem[bank_addr] <= bank_wdata;
        end
        pipe[0] <= (bank_en && !bank_we) ? mem[bank_addr]
                                         : DW'($urandom);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bank_rdata = pipe[LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit            r [2];
    bit            rw [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] held [2];

    bit            active;
    bit            win, prio;
    bit            cur_we, cur_bad;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata, cur_rdata;
    int            g, ack_at, idle_from;
    int            last_win = -1;
    bit            alt_mode;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cyc %0d",
                     tag, act, exp, cyc);
        end
    endtask

    function automatic bit addr_bad(input logic [AW-1:0] a);
`ifdef REG_BANK_ARB_ADDR_CHK_EN
        return int'(a) >= NR;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive();
        req0 = r[0]; we0 = rw[0]; addr0 = ra[0]; wdata0 = rd[0];
        req1 = r[1]; we1 = rw[1]; addr1 = ra[1]; wdata1 = rd[1];
    endtask

    task automatic start(input int p, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!r[p]) begin
            r[p] = 1'b1; rw[p] = we; ra[p] = a; rd[p] = d;
        end
    endtask

    // Compare this cycle's outputs against the transaction model.
    task automatic observe();
        bit a0, a1, en;
        a0 = active && !win && cyc == ack_at;
        a1 = active && win && cyc == ack_at;
        chk("ack0", ack0, a0);
        chk("ack1", ack1, a1);
        chk("busy", busy, active && cyc > g && cyc <= ack_at);
        en = active && !cur_bad && cyc == g + 1;
        chk("bank_en", bank_en, en);
        if (en) begin
            chk("bank_we", bank_we, cur_we);
            chk("bank_addr", bank_addr, cur_addr);
            if (cur_we) chk("bank_wdata", bank_wdata, cur_wdata);
        end
        if (a0 || a1) begin
            if (!cur_we || cur_bad) held[win] = cur_rdata;
            chk(win ? "err1" : "err0", win ? err1 : err0, cur_bad);
            if (alt_mode) chk("alternate", int'(win) != last_win, 1);
            last_win = int'(win);
            active = 1'b0;
            idle_from = cyc + 1;
            prio = ~win;
            r[win] = 1'b0;
        end
        chk("rdata0", rdata0, held[0]);
        chk("rdata1", rdata1, held[1]);
    endtask

    // Grant in the model if idle, then advance one clock.
    task automatic commit();
        if (!active && cyc >= idle_from && (r[0] || r[1])) begin
            win = (r[0] && r[1]) ? prio : r[1];
            active = 1'b1;
            g = cyc;
            cur_we = rw[win];
            cur_addr = ra[win];
            cur_wdata = rd[win];
            cur_bad = addr_bad(cur_addr);
            if (cur_bad) begin
                cur_rdata = '0;
                ack_at = g + 1;
            end else if (cur_we) begin
                shadow[cur_addr] = cur_wdata;
                ack_at = g + 2;
            end else begin
                cur_rdata = shadow[cur_addr];
                ack_at = g + 2 + LAT;
            end
        end
        drive();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while ((active || r[0] || r[1]) && n < maxc) begin
            observe();
            commit();
            n++;
        end
        chk("drain", active | r[0] | r[1], 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        r[0] = 1'b0;
        r[1] = 1'b0;
        drive();
        #1;
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_err0", err0, 0);
        chk("rst_err1", err1, 0);
        chk("rst_bank_en", bank_en, 0);
        chk("rst_bank_we", bank_we, 0);
        chk("rst_bank_addr", bank_addr, 0);
        chk("rst_bank_wdata", bank_wdata, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_busy", busy, 0);
        active = 1'b0;
        prio = 1'b0;
        held[0] = '0;
        held[1] = '0;
        last_win = -1;
        for (int i = 0; i < 256; i++) shadow[i] = DW'(i * 37 + 5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_from = cyc;
    endtask

    initial begin
        #3;
        do_reset();

        start(0, 1'b1, 8'h05, 8'hA5);
        run_idle(20);
        chk("t1_mem5", mem[5], 8'hA5);

        start(1, 1'b0, 8'h05, 8'h00);
        run_idle(20);
        chk("t2_rdata1", rdata1, 8'hA5);
        chk("t2_rdata0", rdata0, 8'h00);

        alt_mode = 1'b1;
        repeat (30) begin
            observe();
            start(0, 1'b0, 8'h01, 8'h00);
            start(1, 1'b0, 8'h02, 8'h00);
            commit();
        end
        alt_mode = 1'b0;
        run_idle(40);

        start(0, 1'b1, 8'h0A, 8'h3C);
        run_idle(20);
        start(1, 1'b0, 8'h0A, 8'h00);
        observe();
        commit();
        observe();
        commit();
        do_reset();
        start(1, 1'b0, 8'h0A, 8'h00);
        run_idle(20);
        start(0, 1'b0, 8'h03, 8'h00);
        start(1, 1'b0, 8'h04, 8'h00);
        run_idle(40);

        start(0, 1'b0, 8'h20, 8'h00);
        run_idle(20);
        start(1, 1'b1, 8'h30, 8'h77);
        run_idle(20);

        repeat (3000) begin
            observe();
            for (int p = 0; p < 2; p++) begin
                if (!r[p] && $urandom_range(0, 2) == 0) begin
                    start(p, 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 40)),
                          DW'($urandom));
                end
            end
            commit();
        end
        run_idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
